// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the clock-enable generator.
//   WIDTH_DEFAULT  default divisor/counter width in bits
//   DIV_DEFAULT    divisor loaded into every channel at reset
//   ch_idx_width   width of a channel-select field (never below 1 bit)
package clk_div_pkg;

    localparam int unsigned WIDTH_DEFAULT = 16;
    localparam int unsigned DIV_DEFAULT   = 49999;

    // A single channel still needs a 1-bit select so out-of-range writes can be expressed.
    function automatic int unsigned ch_idx_width(input int unsigned channels);
        if (channels <= 1) begin
            return 1;
        end
        return unsigned'($clog2(channels));
    endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// clk_enable_gen_if: control and status bundle of the clock-enable generator.
//   run       per-channel run mask (0 freezes the channel)
//   restart   synchronous realign of all channels
//   load      divisor write strobe
//   load_ch   target channel of the write
//   load_val  new divisor value
//   en_out    one-cycle enable pulses
//   clk_out   divided 50 % toggle outputs
//   pending   written divisor not yet active
// master drives the controls, slave is the generator.
interface clk_enable_gen_if
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned WIDTH    = WIDTH_DEFAULT
);

    localparam int unsigned CH_W = ch_idx_width(CHANNELS);

    logic [CHANNELS-1:0] run;
    logic                restart;
    logic                load;
    logic [CH_W-1:0]     load_ch;
    logic [WIDTH-1:0]    load_val;
    logic [CHANNELS-1:0] en_out;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] pending;

    modport master (
        output run, restart, load, load_ch, load_val,
        input  en_out, clk_out, pending
    );

    modport slave (
        input  run, restart, load, load_ch, load_val,
        output en_out, clk_out, pending
    );

endinterface

// File: rtl/clk_enable_chan.sv
// clk_enable_chan: one divider channel.
//   clk_in    clock, all state on the rising edge
//   reset_n   asynchronous active-low reset
//   run       1 = count, 0 = freeze counter and toggle
//   restart   reload counter from the next divisor and clear the toggle
//   wr        divisor write strobe for this channel
//   wr_val    divisor value written
//   en_out    enable pulse, high while running with the counter at zero
//   clk_out   toggle register, flips on every enable pulse
//   pending   a written divisor is waiting for the next terminal count
// A write lands in the shadow divisor and only becomes active when the counter
// reloads, so a running period is never cut short.
module clk_enable_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic             restart,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_val,
    output logic             en_out,
    output logic             clk_out,
    output logic             pending
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_s_q, div_s_d;
    logic             pend_q, pend_d;
    logic             tog_q, tog_d;
    logic             tc;
    logic             reload;
    logic [WIDTH-1:0] div_next;

    assign tc     = (cnt_q == '0);
    assign reload = restart || (run && tc);

    // A write in the same cycle as a reload wins over anything already queued.
    always_comb begin
        div_next = div_a_q;
        if (wr) begin
            div_next = wr_val;
        end else if (pend_q) begin
            div_next = div_s_q;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_a_d = div_a_q;
        div_s_d = div_s_q;
        pend_d  = pend_q;
        tog_d   = tog_q;
        if (reload) begin
            cnt_d   = div_next;
            div_a_d = div_next;
            div_s_d = div_next;
            pend_d  = 1'b0;
            tog_d   = restart ? 1'b0 : ~tog_q;
        end else begin
            if (run) begin
                cnt_d = cnt_q - 1'b1;
            end
            if (wr) begin
                div_s_d = wr_val;
                pend_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= RST_DIV;
            div_a_q <= RST_DIV;
            div_s_q <= RST_DIV;
            pend_q  <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_a_q <= div_a_d;
            div_s_q <= div_s_d;
            pend_q  <= pend_d;
            tog_q   <= tog_d;
        end
    end

    // Decoded from registered state; run is the only combinational path.
    assign en_out  = run && tc;
    assign clk_out = tog_q;
    assign pending = pend_q;

endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel runtime-programmable clock-enable generator.
//   clk_in   sole clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      clk_enable_gen_if.slave: run, restart, load, load_ch, load_val in;
//            en_out, clk_out, pending out
// Each channel pulses en_out every (div+1) cycles and toggles clk_out on each
// pulse. Divisor writes are steered to one channel by load_ch; a select at or
// beyond CHANNELS addresses nothing.
module clk_enable_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    clk_enable_gen_if.slave       bus
);

    localparam int unsigned CH_W = ch_idx_width(CHANNELS);

    logic [CHANNELS-1:0] wr;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign wr[g] = bus.load && (bus.load_ch == CH_W'(g));

        clk_enable_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .run     (bus.run[g]),
            .restart (bus.restart),
            .wr      (wr[g]),
            .wr_val  (bus.load_val),
            .en_out  (bus.en_out[g]),
            .clk_out (bus.clk_out[g]),
            .pending (bus.pending[g])
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Testbench for clk_enable_gen: CHANNELS=3, WIDTH=8, DEFAULT_DIV=4.
// Inputs are driven on the falling edge, outputs sampled 1 time unit later.
module tb_clk_enable_gen;

    typedef struct {
        logic [2:0] run;
        logic       restart;
        logic       load;
        logic [1:0] ch;
        logic [7:0] val;
        logic [2:0] en;
        logic [2:0] clk;
        logic [2:0] pend;
    } vec_t;

    logic clk_in;
    logic reset_n;

    clk_enable_gen_if #(.CHANNELS(3), .WIDTH(8)) bus ();

    clk_enable_gen #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int   n_pass;
    int   n_total;
    vec_t tbl[$];
    vec_t exp_q[$];
    int   a_end;
    int   n;
    logic p;
    logic np;

    function automatic vec_t mk(input logic [2:0] run, input logic rs, input logic ld,
                                input logic [1:0] ch, input logic [7:0] val,
                                input logic [2:0] en, input logic [2:0] clk,
                                input logic [2:0] pend);
        vec_t v;
        v.run = run; v.restart = rs; v.load = ld; v.ch = ch; v.val = val;
        v.en = en; v.clk = clk; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        bus.run      = 3'b111;
        bus.restart  = 1'b0;
        bus.load     = 1'b0;
        bus.load_ch  = 2'd0;
        bus.load_val = 8'd0;
        repeat (2) @(negedge clk_in);
        #1;
        chk("reset en_out", {29'd0, bus.en_out}, 32'd0);
        chk("reset clk_out", {29'd0, bus.clk_out}, 32'd0);
        chk("reset pending", {29'd0, bus.pending}, 32'd0);
        @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    // Expected outputs are queued as each row is driven and retired when sampled.
    task automatic run_rows(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i < hi; i++) begin
            bus.run      = tbl[i].run;
            bus.restart  = tbl[i].restart;
            bus.load     = tbl[i].load;
            bus.load_ch  = tbl[i].ch;
            bus.load_val = tbl[i].val;
            exp_q.push_back(tbl[i]);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d en_out", i), {29'd0, bus.en_out}, {29'd0, e.en});
            chk($sformatf("row%0d clk_out", i), {29'd0, bus.clk_out}, {29'd0, e.clk});
            chk($sformatf("row%0d pending", i), {29'd0, bus.pending}, {29'd0, e.pend});
            @(negedge clk_in);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;

        // A: defaults from reset, then glitch-free reload of ch1 to 2 while cnt1=3.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd7, 3'd0, 3'd0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd7, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 1, 1, 8'd2, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd2));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd2));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd7, 3'd0, 3'd2));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd5, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd5, 3'd5, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 1, 2, 8'd7, 3'd0, 3'd2, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd2, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd2, 3'd4));
        a_end = tbl.size();

        // B: run[2] low for 7 cycles with tog2=1, a write to ch2 while frozen.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd7, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd3, 0, 1, 2, 8'd1, 3'd0, 3'd7, 3'd0));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, 3'd0, 3'd7, 3'd4));
        tbl.push_back(mk(3'd3, 0, 0, 0, 0, 3'd3, 3'd7, 3'd4));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(3'd3, 0, 0, 0, 0, 3'd0, 3'd4, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd4, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd3, 3'd4, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd7, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd4, 3'd7, 3'd4));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd3, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd4, 3'd3, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd3, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd4, 3'd4, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));

        // C: restart with divisors 4/2/6 (ch2 written with restart), then
        // out-of-range write, load+restart on ch0, load at terminal count on ch1.
        tbl.push_back(mk(3'd7, 0, 1, 1, 8'd2, 3'd4, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 1, 1, 2, 8'd6, 3'd0, 3'd4, 3'd2));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd2, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd1, 3'd2, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd3, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd4, 3'd1, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd5, 3'd0));
        tbl.push_back(mk(3'd7, 0, 1, 3, 8'd0, 3'd2, 3'd5, 3'd0));
        tbl.push_back(mk(3'd7, 1, 1, 0, 8'd3, 3'd1, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd0, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd1, 3'd2, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd0, 3'd3, 3'd0));
        tbl.push_back(mk(3'd7, 0, 1, 1, 8'd0, 3'd2, 3'd3, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd6, 3'd1, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd3, 3'd7, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd4, 3'd0));
        tbl.push_back(mk(3'd7, 0, 0, 0, 0, 3'd2, 3'd6, 3'd0));

        do_reset();
        run_rows(0, a_end);

        // Asynchronous reset mid-count: outputs clear with no clock edge.
        #1;
        chk("pre-reset en_out", {29'd0, bus.en_out}, 32'd5);
        chk("pre-reset pending", {29'd0, bus.pending}, 32'd4);
        #1 reset_n = 1'b0;
        #1;
        chk("async reset en_out", {29'd0, bus.en_out}, 32'd0);
        chk("async reset clk_out", {29'd0, bus.clk_out}, 32'd0);
        chk("async reset pending", {29'd0, bus.pending}, 32'd0);

        do_reset();
        run_rows(a_end, tbl.size());

        // div=0 on ch0: written mid-count, so it waits for the terminal count.
        bus.load     = 1'b1;
        bus.load_ch  = 2'd0;
        bus.load_val = 8'd0;
        @(negedge clk_in);
        bus.load = 1'b0;
        #1;
        chk("div0 pending set", {31'd0, bus.pending[0]}, 32'd1);
        n = 0;
        while (bus.pending[0] && n < 10) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("div0 pending cleared", {31'd0, bus.pending[0]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            p = bus.clk_out[0];
            np = ~p;
            @(negedge clk_in);
            #1;
            chk($sformatf("div0 en_out[0] c%0d", i), {31'd0, bus.en_out[0]}, 32'd1);
            chk($sformatf("div0 clk_out[0] c%0d", i), {31'd0, bus.clk_out[0]}, {31'd0, np});
        end

        // div=255: written at a terminal count so it is loaded at once.
        bus.load     = 1'b1;
        bus.load_ch  = 2'd0;
        bus.load_val = 8'hFF;
        @(negedge clk_in);
        bus.load = 1'b0;
        #1;
        chk("div255 no pending", {31'd0, bus.pending[0]}, 32'd0);
        n = 1;
        while (!bus.en_out[0] && n < 600) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("div255 first pulse distance", n, 32'd256);
        n = 0;
        do begin
            @(negedge clk_in);
            #1;
            n++;
        end while (!bus.en_out[0] && n < 600);
        chk("div255 period", n, 32'd256);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
